// File: rtl/matrix_stream_source.sv
// AXI4-Stream source: each frame is matrix A then B = 2*I, row-major, one 32-bit element per beat.
// Streams Num_Frames frames after a start delay, then parks in a sticky done state.
module matrix_stream_source #(
    parameter int          N           = 6,
    parameter int          Num_Frames  = 3,
    parameter logic [19:0] Start_Delay = 20'd20,
    parameter logic [7:0]  Gap_Cycles  = 8'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        input_r_TREADY_0,
    output logic        input_r_TVALID_0,
    output logic [31:0] input_r_TDATA_0,
    output logic        input_r_TLAST_0,
    output logic [3:0]  frame_count,
    output logic        done
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    typedef enum logic [2:0] {IDLE, DELAY, STREAM, GAP, DONE} state_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] row, row_next;
    logic [IDX_W-1:0] col, col_next;
    logic             in_b, in_b_next;
    logic [3:0]       fc_next;
    logic [19:0]      dly_cnt, dly_next;
    logic [7:0]       gap_cnt, gap_next;
    logic             last_beat;
    logic             xfer;
    logic             last_next;
    logic [31:0]      data_next;

    // Beat position is tracked as (matrix select, row, col) instead of a flat index.
    always_comb begin
        state_next = state;
        row_next   = row;
        col_next   = col;
        in_b_next  = in_b;
        fc_next    = frame_count;
        dly_next   = dly_cnt;
        gap_next   = gap_cnt;
        last_beat  = in_b && (row == IDX_MAX) && (col == IDX_MAX);
        xfer       = input_r_TVALID_0 && input_r_TREADY_0;

        case (state)
            IDLE: begin
                if (enable) begin
                    row_next   = '0;
                    col_next   = '0;
                    in_b_next  = 1'b0;
                    dly_next   = '0;
                    state_next = (Start_Delay == 20'd0) ? STREAM : DELAY;
                end
            end
            DELAY: begin
                if (dly_cnt == Start_Delay - 20'd1) begin
                    state_next = STREAM;
                end else begin
                    dly_next = dly_cnt + 20'd1;
                end
            end
            STREAM: begin
                if (xfer) begin
                    if (last_beat) begin
                        fc_next   = frame_count + 4'd1;
                        row_next  = '0;
                        col_next  = '0;
                        in_b_next = 1'b0;
                        gap_next  = '0;
                        if (fc_next == 4'(Num_Frames)) begin
                            state_next = DONE;
                        end else if (Gap_Cycles != 8'd0) begin
                            state_next = GAP;
                        end
                    end else if (col == IDX_MAX) begin
                        col_next = '0;
                        if (row == IDX_MAX) begin
                            row_next  = '0;
                            in_b_next = 1'b1;
                        end else begin
                            row_next = row + 1'b1;
                        end
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == Gap_Cycles - 8'd1) begin
                    state_next = STREAM;
                end else begin
                    gap_next = gap_cnt + 8'd1;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are precomputed from the next position so they can be registered.
        if (in_b_next) begin
            data_next = (row_next == col_next) ? 32'd2 : 32'd0;
        end else begin
            data_next = 32'(row_next) + 32'(col_next) + 32'(fc_next) + 32'd1;
        end
        last_next = in_b_next && (row_next == IDX_MAX) && (col_next == IDX_MAX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            row              <= '0;
            col              <= '0;
            in_b             <= 1'b0;
            frame_count      <= '0;
            dly_cnt          <= '0;
            gap_cnt          <= '0;
            input_r_TVALID_0 <= 1'b0;
            input_r_TDATA_0  <= '0;
            input_r_TLAST_0  <= 1'b0;
            done             <= 1'b0;
        end else begin
            state            <= state_next;
            row              <= row_next;
            col              <= col_next;
            in_b             <= in_b_next;
            frame_count      <= fc_next;
            dly_cnt          <= dly_next;
            gap_cnt          <= gap_next;
            input_r_TVALID_0 <= (state_next == STREAM);
            input_r_TDATA_0  <= (state_next == STREAM) ? data_next : 32'd0;
            input_r_TLAST_0  <= (state_next == STREAM) && last_next;
            done             <= (state_next == DONE);
        end
    end
endmodule

// File: tb/tb_matrix_stream_source.sv
// Self-checking bench for matrix_stream_source: default and zero-delay/zero-gap instances
// compared against an arithmetic model of the frame contents.
module tb_matrix_stream_source;
    localparam int N      = 6;
    localparam int NN     = N * N;
    localparam int FRAME  = 2 * NN;
    localparam int FRAMES = 3;
    localparam int TOTAL  = FRAME * FRAMES;

    logic        clk = 1'b0;
    logic        rst_n, enable, tready;
    logic        tvalid, tlast, done;
    logic [31:0] tdata;
    logic [3:0]  fc;
    logic        z_rst_n, z_enable, z_tready;
    logic        z_tvalid, z_tlast, z_done;
    logic [31:0] z_tdata;
    logic [3:0]  z_fc;

    int tests_run = 0;
    int failures  = 0;

    always #5 clk = ~clk;

    matrix_stream_source dut (
        .clk              (clk),
        .reset            (rst_n),
        .enable           (enable),
        .input_r_TREADY_0 (tready),
        .input_r_TVALID_0 (tvalid),
        .input_r_TDATA_0  (tdata),
        .input_r_TLAST_0  (tlast),
        .frame_count      (fc),
        .done             (done)
    );

    matrix_stream_source #(
        .N           (N),
        .Num_Frames  (FRAMES),
        .Start_Delay (20'd0),
        .Gap_Cycles  (8'd0)
    ) dut_z (
        .clk              (clk),
        .reset            (z_rst_n),
        .enable           (z_enable),
        .input_r_TREADY_0 (z_tready),
        .input_r_TVALID_0 (z_tvalid),
        .input_r_TDATA_0  (z_tdata),
        .input_r_TLAST_0  (z_tlast),
        .frame_count      (z_fc),
        .done             (z_done)
    );

    // Element value for frame f, beat w: A[r][c] = r+c+f+1, then B = 2*I.
    function automatic logic [31:0] model_data(int f, int w);
        if (w < NN) return 32'((w / N) + (w % N) + f + 1);
        return (((w - NN) / N) == (w % N)) ? 32'd2 : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart_default();
        rst_n  = 1'b0;
        enable = 1'b0;
        tready = 1'b1;
        step();
        step();
        rst_n  = 1'b1;
        enable = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        z_rst_n = 1'b0;
        step();
        step();
        tests_run++;
        if ({tvalid, tlast, tdata, fc, done} !== 39'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got valid=%0b last=%0b data=%0d fc=%0d done=%0b, want all 0",
                     tvalid, tlast, tdata, fc, done);
        end
        tests_run++;
        if ({z_tvalid, z_tlast, z_tdata, z_fc, z_done} !== 39'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs_z: got valid=%0b last=%0b data=%0d fc=%0d done=%0b, want all 0",
                     z_tvalid, z_tlast, z_tdata, z_fc, z_done);
        end
    endtask

    task automatic test_default_stream();
        int cycles;
        int beats;
        int gap;
        rst_n  = 1'b1;
        tready = 1'b1;
        #250;
        enable = 1'b1;
        step();
        cycles = 0;
        while (tvalid !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        tests_run++;
        if (cycles != 20) begin
            failures++;
            $display("[TB] FAIL first_valid_delay: got %0d cycles, want 20", cycles);
        end
        beats = 0;
        gap   = -1;
        for (int cyc = 0; cyc < 1000 && beats < TOTAL; cyc++) begin
            if (tvalid === 1'b1) begin
                if (gap >= 0) begin
                    tests_run++;
                    if (gap != 4) begin
                        failures++;
                        $display("[TB] FAIL inter_frame_gap: got %0d idle cycles, want 4", gap);
                    end
                    gap = -1;
                end
                tests_run++;
                if ({tlast, tdata} !== {(beats % FRAME) == FRAME - 1, model_data(beats / FRAME, beats % FRAME)}) begin
                    failures++;
                    $display("[TB] FAIL beat_default %0d: got data=%0d last=%0b, want data=%0d last=%0b",
                             beats, tdata, tlast, model_data(beats / FRAME, beats % FRAME),
                             (beats % FRAME) == FRAME - 1);
                end
                tests_run++;
                if (fc !== 4'(beats / FRAME)) begin
                    failures++;
                    $display("[TB] FAIL frame_count_default beat %0d: got %0d, want %0d", beats, fc, beats / FRAME);
                end
                if ((beats % FRAME) == FRAME - 1) gap = 0;
                beats++;
            end else if (gap >= 0) begin
                gap++;
            end
            step();
        end
        tests_run++;
        if (beats != TOTAL || done !== 1'b1 || fc !== 4'd3 || tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL default_done: got beats=%0d done=%0b fc=%0d valid=%0b, want 216 1 3 0",
                     beats, done, fc, tvalid);
        end
    endtask

    task automatic test_random_ready();
        int          beats;
        bit          stalled;
        logic [31:0] p_data;
        logic        p_last;
        restart_default();
        beats   = 0;
        stalled = 1'b0;
        p_data  = '0;
        p_last  = 1'b0;
        for (int cyc = 0; cyc < 3000 && beats < TOTAL; cyc++) begin
            if (stalled) begin
                tests_run++;
                if (tvalid !== 1'b1 || {tlast, tdata} !== {p_last, p_data}) begin
                    failures++;
                    $display("[TB] FAIL stall_hold beat %0d: got valid=%0b data=%0d last=%0b, want valid=1 data=%0d last=%0b",
                             beats, tvalid, tdata, tlast, p_data, p_last);
                end
            end
            tready = 1'($urandom_range(0, 1));
            stalled = 1'b0;
            if (tvalid === 1'b1) begin
                if (tready) begin
                    tests_run++;
                    if ({tlast, tdata} !== {(beats % FRAME) == FRAME - 1, model_data(beats / FRAME, beats % FRAME)}) begin
                        failures++;
                        $display("[TB] FAIL beat_random %0d: got data=%0d last=%0b, want data=%0d last=%0b",
                                 beats, tdata, tlast, model_data(beats / FRAME, beats % FRAME),
                                 (beats % FRAME) == FRAME - 1);
                    end
                    beats++;
                end else begin
                    stalled = 1'b1;
                    p_data  = tdata;
                    p_last  = tlast;
                end
            end
            step();
        end
        step();
        tests_run++;
        if (beats != TOTAL || done !== 1'b1 || fc !== 4'd3 || tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL random_done: got beats=%0d done=%0b fc=%0d valid=%0b, want 216 1 3 0",
                     beats, done, fc, tvalid);
        end
        tready = 1'b1;
    endtask

    task automatic test_zero_gap();
        z_tready = 1'b1;
        z_rst_n  = 1'b1;
        step();
        z_enable = 1'b1;
        step();
        tests_run++;
        if (z_tvalid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_delay_valid: got %0b, want 1", z_tvalid);
        end
        for (int b = 0; b < TOTAL; b++) begin
            tests_run++;
            if (z_tvalid !== 1'b1 ||
                {z_tlast, z_tdata} !== {(b % FRAME) == FRAME - 1, model_data(b / FRAME, b % FRAME)}) begin
                failures++;
                $display("[TB] FAIL beat_zero_gap %0d: got valid=%0b data=%0d last=%0b, want valid=1 data=%0d last=%0b",
                         b, z_tvalid, z_tdata, z_tlast, model_data(b / FRAME, b % FRAME), (b % FRAME) == FRAME - 1);
            end
            step();
        end
        tests_run++;
        if (z_done !== 1'b1 || z_fc !== 4'd3 || z_tvalid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_gap_done: got done=%0b fc=%0d valid=%0b, want 1 3 0", z_done, z_fc, z_tvalid);
        end
    endtask

    task automatic test_reset_midframe();
        int beats;
        int cycles;
        restart_default();
        beats = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (tvalid === 1'b1) begin
                if (beats == FRAME + 40) break;
                beats++;
            end
            step();
        end
        tests_run++;
        if (beats != FRAME + 40 || tvalid !== 1'b1 || tdata !== model_data(1, 40)) begin
            failures++;
            $display("[TB] FAIL reach_frame1_beat40: got beats=%0d valid=%0b data=%0d, want 112 1 %0d",
                     beats, tvalid, tdata, model_data(1, 40));
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({tvalid, tlast, tdata, fc, done} !== 39'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got valid=%0b last=%0b data=%0d fc=%0d done=%0b, want all 0",
                     tvalid, tlast, tdata, fc, done);
        end
        enable = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        step();
        enable = 1'b1;
        step();
        cycles = 0;
        while (tvalid !== 1'b1 && cycles < 100) begin
            step();
            cycles++;
        end
        tests_run++;
        if (cycles != 20 || tdata !== 32'd1 || fc !== 4'd0 || tlast !== 1'b0) begin
            failures++;
            $display("[TB] FAIL restart_after_reset: got cycles=%0d data=%0d fc=%0d last=%0b, want 20 1 0 0",
                     cycles, tdata, fc, tlast);
        end
    endtask

    task automatic test_enable_toggle();
        int beats;
        restart_default();
        beats = 0;
        for (int cyc = 0; cyc < 1000 && beats < TOTAL; cyc++) begin
            enable = (beats == 10) ? 1'b0 : 1'($urandom_range(0, 1));
            if (tvalid === 1'b1) begin
                tests_run++;
                if ({tlast, tdata} !== {(beats % FRAME) == FRAME - 1, model_data(beats / FRAME, beats % FRAME)}) begin
                    failures++;
                    $display("[TB] FAIL beat_enable_toggle %0d: got data=%0d last=%0b, want data=%0d last=%0b",
                             beats, tdata, tlast, model_data(beats / FRAME, beats % FRAME),
                             (beats % FRAME) == FRAME - 1);
                end
                beats++;
            end
            step();
        end
        tests_run++;
        if (beats != TOTAL) begin
            failures++;
            $display("[TB] FAIL enable_toggle_beats: got %0d, want 216", beats);
        end
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            tests_run++;
            if (done !== 1'b1 || tvalid !== 1'b0 || fc !== 4'd3) begin
                failures++;
                $display("[TB] FAIL done_sticky cycle %0d: got done=%0b valid=%0b fc=%0d, want 1 0 3",
                         i, done, tvalid, fc);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        tready   = 1'b1;
        z_rst_n  = 1'b0;
        z_enable = 1'b0;
        z_tready = 1'b1;
        #3;
        test_reset();
        test_default_stream();
        test_random_ready();
        test_zero_gap();
        test_reset_midframe();
        test_enable_toggle();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule

// File: doc/matrix_stream_source.md
Name: matrix_stream_source

Overview:
- AXI4-Stream stimulus source feeding the matrix multiplier core's input_r port; directly upstream of the multiplier whose output_r stream goes to the result checker.
- Each frame is matrix A then matrix B, row-major, one 32-bit element per beat.
- B is 2·I, so every expected product element is exactly 2·A[r][c]. The downstream checker can compute expected values without a stored table.
- Streams Num_Frames frames after a start delay, then parks in a sticky done state.

Parameters:
- N, 6, matrix dimension; frame length is 2·N·N beats (72 at default).
- Num_Frames, 3, frames per run; default total is 216 beats, 1..15 legal.
- Start_Delay, 20'd20, cycles spent in DELAY before the first beat; 0 is legal.
- Gap_Cycles, 8'd4, idle cycles between frames; 0 is legal.

Ports:
- clk, input, 1, single clock, rising edge.
- reset, input, 1, asynchronous active-low reset; reset=0 clears all state.
- enable, input, 1, level start request, sampled only in IDLE.
- input_r_TREADY_0, input, 1, sink ready.
- input_r_TVALID_0, output, 1, beat valid.
- input_r_TDATA_0, output, 32, element value.
- input_r_TLAST_0, output, 1, high on the final beat of each frame.
- frame_count, output, 4, frames fully transferred.
- done, output, 1, high once all frames have transferred.

Behaviour:
- Reset (asynchronous, reset=0): TVALID=0, TLAST=0, TDATA=0, frame_count=0, done=0, state=IDLE. All counters go to 0. Reset mid-frame aborts the frame immediately, with no completion of the partial frame.
- States: IDLE, DELAY, STREAM, GAP, DONE.
- IDLE -> DELAY when enable=1. If Start_Delay=0, IDLE -> STREAM directly, and TVALID is high on the cycle after enable is sampled.
- DELAY: the delay counter runs from 0. Transition DELAY -> STREAM happens after Start_Delay cycles.
- STREAM:
  - All outputs are registered.
  - A transfer occurs when TVALID && TREADY at a rising edge.
  - While TVALID=1 && TREADY=0, TDATA and TLAST hold stable.
  - TVALID never drops without a transfer.
  - Beat index w runs 0..2N²-1; r=(w mod N²)/N, c=w mod N, f=frame_count.
  - w < N²: TDATA = r+c+f+1 (matrix A).
  - w ≥ N²: TDATA = 2 if r==c, else 0 (matrix B).
  - TLAST=1 only at w=2N²-1.
  - After each transfer the next beat is presented the following cycle, giving back-to-back throughput of 1 beat/cycle when TREADY is held high.
- Transfer of the TLAST beat:
  - frame_count increments on the same edge.
  - If the new count equals Num_Frames: go to DONE, with TVALID=0 and done=1 on the next cycle.
  - Otherwise, if Gap_Cycles>0: go to GAP with TVALID=0.
  - Otherwise (Gap_Cycles=0): stay in STREAM with w=0; the first beat of the next frame is presented immediately with no bubble.
- GAP: TVALID=0 for exactly Gap_Cycles cycles, then STREAM with w=0.
- DONE: sticky until reset. TVALID=0, done=1, frame_count=Num_Frames. enable is ignored.
- enable changes outside IDLE have no effect.
- Arithmetic: counters are sized to hold 2N², Start_Delay and Gap_Cycles without wrap. TDATA is computed unsigned and zero-extended to 32 bits.
- frame_count saturates at Num_Frames and never wraps.

Test Plan:
- Defaults, TREADY=1 constant, enable raised 250 ns after reset release:
  - first TVALID appears 20 cycles after DELAY entry;
  - first three beats are TDATA 1, 2, 3;
  - beat 36 is 2, beat 37 is 0;
  - TLAST appears on beats 71, 143 and 215;
  - 4 idle cycles occur between frames;
  - done=1 and frame_count=3 after 216 transfers.
- Random TREADY with 50% duty:
  - TDATA/TLAST are stable on every stalled cycle;
  - 216 transfers occur in total, with none lost or duplicated;
  - per-frame data is identical to the TREADY=1 run.
- Gap_Cycles=0, Start_Delay=0:
  - TVALID is continuous for all 216 beats with TREADY=1;
  - frame 1 beat 0 is 2 (f=1), immediately following the TLAST of frame 0.
- Reset (reset=0) asserted at beat 40 of frame 1:
  - all outputs are 0 within the same time step, without waiting for a clock;
  - after release and re-enable, the run restarts with frame 0, beat 0 = 1.
- enable toggling:
  - enable pulse low at beat 10: no effect on the stream;
  - enable held high after DONE: no restart, done stays 1.
